// File: rtl/xge_pkt_rx_checker.sv
// xge_pkt_rx_checker: pulls frames from the MAC pkt_rx interface, checks seq/length/payload, keeps saturating stats.
module xge_pkt_rx_checker #(
  parameter int CNT_W = 32,
  parameter int BYTE_W = 48,
  parameter int MAX_WORDS = 1520
) (
  input  logic              clk_156,
  input  logic              reset_156,
  input  logic              enable,
  input  logic              clear_cnt,
  input  logic              pkt_rx_avail,
  output logic              pkt_rx_ren,
  input  logic              pkt_rx_val,
  input  logic              pkt_rx_sop,
  input  logic              pkt_rx_eop,
  input  logic [2:0]        pkt_rx_mod,
  input  logic              pkt_rx_err,
  input  logic [63:0]       pkt_rx_data,
  output logic              busy,
  output logic [CNT_W-1:0]  rx_pkt_cnt,
  output logic [BYTE_W-1:0] rx_byte_cnt,
  output logic [CNT_W-1:0]  mac_err_cnt,
  output logic [CNT_W-1:0]  seq_err_cnt,
  output logic [CNT_W-1:0]  len_err_cnt,
  output logic [CNT_W-1:0]  pay_err_cnt,
  output logic [CNT_W-1:0]  proto_err_cnt
);
  localparam int WC_W = $clog2(MAX_WORDS + 1);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, GAP = 2'd2;
  logic [1:0] state;
  logic [WC_W-1:0] wc;
  logic [31:0] exp_seq, seq;
  logic [15:0] len;
  logic [WC_W+3:0] fbytes;
  logic ferr, pay_bad, short_f, ovf, drain;
  logic rd_val, ovf_now, stat;
  logic [3:0] nb;
  logic [63:0] mask, exp_word;
  logic [1:0] proto_inc;
  logic [BYTE_W:0] bsum;
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c, input logic [1:0] i);
    logic [CNT_W:0] s;
    s = {1'b0, c} + {{(CNT_W-1){1'b0}}, i};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction
  assign rd_val = state == READ && pkt_rx_val;
  assign nb = pkt_rx_mod == 3'd0 ? 4'd8 : {1'b0, pkt_rx_mod};
  assign mask = pkt_rx_eop ? ~64'd0 << (7'd64 - {nb, 3'b000}) : ~64'd0;
  assign exp_word = {seq, 32'(wc)};
  assign ovf_now = rd_val && !pkt_rx_eop && wc == WC_W'(MAX_WORDS - 1);
  // drained words after an oversize abort are expected and not protocol errors
  assign proto_inc = 2'(rd_val && ((wc == '0) != pkt_rx_sop)) + 2'(ovf_now)
                   + 2'(pkt_rx_val && state != READ && !drain);
  assign stat = state == GAP && !ovf;
  assign pkt_rx_ren = !reset_156 && (state == READ || drain) && !(pkt_rx_val && pkt_rx_eop);
  assign busy = state == READ || state == GAP;
  assign bsum = {1'b0, rx_byte_cnt} + (stat ? {{(BYTE_W-WC_W-3){1'b0}}, fbytes} : '0);
  always_ff @(posedge clk_156) begin
    if (reset_156) begin
      state <= IDLE;
      wc <= '0;
      exp_seq <= '0;
      seq <= '0;
      len <= '0;
      fbytes <= '0;
      ferr <= 1'b0;
      pay_bad <= 1'b0;
      short_f <= 1'b0;
      ovf <= 1'b0;
      drain <= 1'b0;
      rx_pkt_cnt <= '0;
      rx_byte_cnt <= '0;
      mac_err_cnt <= '0;
      seq_err_cnt <= '0;
      len_err_cnt <= '0;
      pay_err_cnt <= '0;
      proto_err_cnt <= '0;
    end else begin
      state <= state == IDLE ? (enable && pkt_rx_avail && !clear_cnt && !drain ? READ : IDLE)
             : state == READ ? ((rd_val && pkt_rx_eop) || ovf_now ? GAP : READ) : IDLE;
      if (state == IDLE) begin
        wc <= '0;
        pay_bad <= 1'b0;
        ovf <= 1'b0;
      end else if (rd_val) wc <= wc + 1'b1;
      if (rd_val && wc == WC_W'(1)) begin
        seq <= pkt_rx_data[63:32];
        len <= pkt_rx_data[15:0];
      end
      if (rd_val && wc >= WC_W'(2) && |((pkt_rx_data ^ exp_word) & mask)) pay_bad <= 1'b1;
      if (rd_val && pkt_rx_eop) begin
        ferr <= pkt_rx_err;
        fbytes <= {1'b0, wc, 3'b000} + {{WC_W{1'b0}}, nb};
        short_f <= wc == '0;
      end
      if (ovf_now) begin
        ovf <= 1'b1;
        drain <= 1'b1;
      end else if (drain && pkt_rx_val && pkt_rx_eop) drain <= 1'b0;
      if (clear_cnt) begin
        exp_seq <= '0;
        rx_pkt_cnt <= '0;
        rx_byte_cnt <= '0;
        mac_err_cnt <= '0;
        seq_err_cnt <= '0;
        len_err_cnt <= '0;
        pay_err_cnt <= '0;
        proto_err_cnt <= '0;
      end else begin
        if (stat && !short_f) exp_seq <= seq + 32'd1;
        rx_pkt_cnt <= sat(rx_pkt_cnt, 2'(stat));
        rx_byte_cnt <= bsum[BYTE_W] ? '1 : bsum[BYTE_W-1:0];
        mac_err_cnt <= sat(mac_err_cnt, 2'(stat && ferr));
        seq_err_cnt <= sat(seq_err_cnt, 2'(stat && !short_f && seq != exp_seq));
        len_err_cnt <= sat(len_err_cnt, 2'(stat && !short_f && 32'(len) != 32'(fbytes)));
        pay_err_cnt <= sat(pay_err_cnt, 2'(stat && !short_f && pay_bad));
        proto_err_cnt <= sat(proto_err_cnt, proto_inc);
      end
    end
  end
endmodule

// File: tb/tb_xge_pkt_rx_checker.sv
// tb_xge_pkt_rx_checker: MAC-side frame source, frame-level reference model, table and random checks.
module tb_xge_pkt_rx_checker;
  localparam int CW = 5;
  localparam int MW = 16;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, rst = 1, enable = 1, clear_cnt = 0, avail = 0, ren;
  logic val = 0, sop = 0, eop = 0, err = 0, busy;
  logic [2:0] mod = 0;
  logic [63:0] data = 0;
  logic [CW-1:0] pkt, mac, seqe, lene, paye, proto;
  logic [47:0] bytes;
  typedef struct {logic sop, eop, err; logic [2:0] mod; logic [63:0] data;} word_t;
  typedef struct {int nw; int seq; int len; int mod; bit err; int cw; int cb; bit nosop;} fr_t;
  typedef struct {fr_t f; int pkt; longint bytes; int mac, seqe, lene, paye, proto;} row_t;
  word_t q[$];
  row_t tbl[11];
  int errors = 0, checks = 0;
  int m_pkt, m_mac, m_seqe, m_lene, m_paye, m_proto, m_exp;
  longint m_bytes;
  bit pend_clr = 0, clr_gap = 0, last_eop = 0, r_s = 0, busy_s = 0;
  int ren_viol = 0, over = 0;

  xge_pkt_rx_checker #(.CNT_W(CW), .BYTE_W(48), .MAX_WORDS(MW)) dut (
    .clk_156(clk), .reset_156(rst), .enable(enable), .clear_cnt(clear_cnt),
    .pkt_rx_avail(avail), .pkt_rx_ren(ren), .pkt_rx_val(val), .pkt_rx_sop(sop),
    .pkt_rx_eop(eop), .pkt_rx_mod(mod), .pkt_rx_err(err), .pkt_rx_data(data),
    .busy(busy), .rx_pkt_cnt(pkt), .rx_byte_cnt(bytes), .mac_err_cnt(mac),
    .seq_err_cnt(seqe), .len_err_cnt(lene), .pay_err_cnt(paye), .proto_err_cnt(proto));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_pkt, input longint e_bytes, input int e_mac,
                         input int e_seq, input int e_len, input int e_pay, input int e_proto);
    chk({tag, " pkt"}, 64'(pkt), 64'(e_pkt));
    chk({tag, " bytes"}, 64'(bytes), 64'(e_bytes));
    chk({tag, " mac_err"}, 64'(mac), 64'(e_mac));
    chk({tag, " seq_err"}, 64'(seqe), 64'(e_seq));
    chk({tag, " len_err"}, 64'(lene), 64'(e_len));
    chk({tag, " pay_err"}, 64'(paye), 64'(e_pay));
    chk({tag, " proto_err"}, 64'(proto), 64'(e_proto));
  endtask

  function automatic int sat(input int x);
    return x > CMAX ? CMAX : x;
  endfunction

  // frame-level model: what one complete frame does to the counters
  task automatic model(input fr_t f, input bit clr);
    int n, fb;
    n = f.mod == 0 ? 8 : f.mod;
    fb = 8 * (f.nw - 1) + n;
    if (clr) begin
      {m_pkt, m_mac, m_seqe, m_lene, m_paye, m_proto, m_exp} = '0;
      m_bytes = 0;
      return;
    end
    m_proto = sat(m_proto + int'(f.nosop));
    if (f.nw > MW) begin
      m_proto = sat(m_proto + 1);
      return;
    end
    m_pkt = sat(m_pkt + 1);
    m_bytes += fb;
    m_mac = sat(m_mac + int'(f.err));
    if (f.nw >= 2) begin
      m_seqe = sat(m_seqe + int'(f.seq != m_exp));
      m_lene = sat(m_lene + int'(f.len != fb));
      m_paye = sat(m_paye + int'(f.cw >= 2 && f.cw < f.nw && !(f.cw == f.nw - 1 && f.cb < 8 - n)));
      m_exp = f.seq + 1;
    end
  endtask

  task automatic push(input fr_t f, input bit clr);
    word_t w;
    logic [31:0] s;
    s = f.seq;
    for (int k = 0; k < f.nw; k++) begin
      w.sop = k == 0 && !f.nosop;
      w.eop = k == f.nw - 1;
      w.mod = w.eop ? 3'(f.mod) : 3'd0;
      w.err = w.eop && f.err;
      w.data = k == 0 ? {$urandom, $urandom} : k == 1 ? {s, 16'($urandom), 16'(f.len)} : {s, 32'(k)};
      if (k == f.cw) w.data ^= 64'hFF << (8 * f.cb);
      q.push_back(w);
    end
    model(f, clr);
  endtask

  task automatic step();
    word_t w;
    @(negedge clk);
    r_s = ren;
    busy_s = busy;
    if (last_eop && r_s) ren_viol++;
    @(posedge clk);
    #1;
    clear_cnt = pend_clr;
    pend_clr = 0;
    last_eop = 0;
    val = 0;
    if (r_s) begin
      if (q.size() > 0) begin
        w = q.pop_front();
        {val, sop, eop, mod, err, data} = {1'b1, w.sop, w.eop, w.mod, w.err, w.data};
        last_eop = w.eop;
        if (w.eop && clr_gap) pend_clr = 1;
      end else over++;
    end
    avail = q.size() > 0;
  endtask

  task automatic run();
    int n = 0;
    do begin
      step();
      n++;
    end while ((q.size() > 0 || busy_s || pend_clr) && n < 2000);
    if (n >= 2000) begin
      errors++;
      $display("FAIL run_timeout: got %0d cycles expected completion", n);
    end
    repeat (2) step();
  endtask

  task automatic clr();
    pend_clr = 1;
    step();
    step();
    model('{default: 0}, 1);
  endtask

  initial begin
    fr_t f;
    int fb;
    tbl[0]  = '{'{8, 0, 64, 0, 0, -1, 0, 0},   1, 64,  0, 0, 0, 0, 0};
    tbl[1]  = '{'{8, 5, 64, 0, 0, -1, 0, 0},   2, 128, 0, 1, 0, 0, 0};
    tbl[2]  = '{'{8, 6, 64, 0, 0, -1, 0, 0},   3, 192, 0, 1, 0, 0, 0};
    tbl[3]  = '{'{8, 7, 61, 5, 0, 7, 2, 0},    4, 253, 0, 1, 0, 0, 0};
    tbl[4]  = '{'{8, 8, 61, 5, 0, 7, 7, 0},    5, 314, 0, 1, 0, 1, 0};
    tbl[5]  = '{'{8, 9, 100, 0, 1, -1, 0, 0},  6, 378, 1, 1, 1, 1, 0};
    tbl[6]  = '{'{8, 10, 64, 0, 0, -1, 0, 1},  7, 442, 1, 1, 1, 1, 1};
    tbl[7]  = '{'{20, 11, 160, 0, 0, -1, 0, 0}, 7, 442, 1, 1, 1, 1, 2};
    tbl[8]  = '{'{8, 11, 64, 0, 0, -1, 0, 0},  8, 506, 1, 1, 1, 1, 2};
    tbl[9]  = '{'{1, 0, 0, 3, 0, -1, 0, 0},    9, 509, 1, 1, 1, 1, 2};
    tbl[10] = '{'{2, 12, 16, 0, 0, -1, 0, 0}, 10, 525, 1, 1, 1, 1, 2};
    model('{default: 0}, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset ren", 64'(ren), 0);
    chk("reset busy", 64'(busy), 0);
    @(posedge clk);
    #1 rst = 0;
    for (int s = 0; s < 3; s++) push('{8, s, 64, 0, 0, -1, 0, 0}, 0);
    run();
    chk_all("b2b", 3, 192, 0, 0, 0, 0, 0);
    clr();
    for (int i = 0; i < 11; i++) begin
      push(tbl[i].f, 0);
      run();
      chk_all($sformatf("tbl%0d", i), tbl[i].pkt, tbl[i].bytes, tbl[i].mac, tbl[i].seqe,
              tbl[i].lene, tbl[i].paye, tbl[i].proto);
    end
    push('{8, 13, 64, 0, 0, -1, 0, 0}, 0);
    repeat (4) step();
    enable = 0;
    run();
    chk("en_off midframe pkt", 64'(pkt), 11);
    push('{8, 14, 64, 0, 0, -1, 0, 0}, 0);
    repeat (20) step();
    chk("en_off idle pkt", 64'(pkt), 11);
    chk("en_off idle busy", 64'(busy_s), 0);
    enable = 1;
    run();
    chk("en_on pkt", 64'(pkt), 12);
    clr();
    for (int i = 0; i < CMAX; i++) push('{1, 0, 0, 0, 0, -1, 0, 0}, 0);
    run();
    chk("sat fill pkt", 64'(pkt), 64'(CMAX));
    push('{1, 0, 0, 0, 0, -1, 0, 0}, 0);
    run();
    chk("sat hold pkt", 64'(pkt), 64'(CMAX));
    chk("sat hold bytes", 64'(bytes), 256);
    clr_gap = 1;
    push('{8, 0, 64, 0, 0, -1, 0, 0}, 1);
    run();
    clr_gap = 0;
    chk("gap clear pkt", 64'(pkt), 0);
    chk("gap clear bytes", 64'(bytes), 0);
    clr();
    for (int i = 0; i < 40; i++) begin
      f.nw = $urandom_range(1, 20);
      f.seq = $urandom_range(0, 3) == 0 ? int'($urandom) : m_exp;
      f.mod = $urandom_range(0, 7);
      fb = 8 * (f.nw - 1) + (f.mod == 0 ? 8 : f.mod);
      f.len = $urandom_range(0, 3) == 0 ? $urandom_range(0, 1000) : fb;
      f.err = $urandom_range(0, 7) == 0;
      f.cw = (f.nw >= 3 && $urandom_range(0, 2) == 0) ? $urandom_range(2, f.nw - 1) : -1;
      f.cb = $urandom_range(0, 7);
      f.nosop = $urandom_range(0, 9) == 0;
      clr_gap = $urandom_range(0, 14) == 0;
      push(f, clr_gap);
      run();
      clr_gap = 0;
      chk_all($sformatf("rnd%0d", i), m_pkt, m_bytes, m_mac, m_seqe, m_lene, m_paye, m_proto);
    end
    push('{8, 0, 64, 0, 0, -1, 0, 0}, 0);
    repeat (5) step();
    rst = 1;
    #1 chk("midreset ren", 64'(ren), 0);
    step();
    step();
    chk("midreset busy", 64'(busy_s), 0);
    chk("midreset pkt", 64'(pkt), 0);
    q.delete();
    rst = 0;
    chk("ren low on eop", 64'(ren_viol), 0);
    chk("no overread", 64'(over), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
